// File: rtl/clock_pkg.sv
// Shared types and helpers for the multi-channel clock/strobe generator.
// Config clamping lives here so every channel applies identical rules.
package clock_pkg;

  localparam int C_MIN_PERIOD = 2;
  localparam int C_CFG_W      = 32;

  typedef logic [C_CFG_W-1:0] cfg_word_t;

  typedef struct packed {
    cfg_word_t n;
    cfg_word_t h;
  } cfg_t;

  // Period is raised to the minimum; high time is capped at the period,
  // which makes cnt < h true for every count (constant-high channel).
  function automatic cfg_t clamp_cfg(input cfg_word_t n, input cfg_word_t h);
    cfg_t c;
    c.n = (n < cfg_word_t'(C_MIN_PERIOD)) ? cfg_word_t'(C_MIN_PERIOD) : n;
    c.h = (h > c.n) ? c.n : h;
    return c;
  endfunction

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int ch_sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/clock_channel.sv
// One divider channel: counter, active/shadow config, registered level and
// edge pulses. New settings take effect only at a period boundary or on sync.
module clock_channel
  import clock_pkg::*;
#(
  parameter int p_width          = 16,
  parameter int p_default_period = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stop,
  input  logic               sync,
  input  logic               wr,
  input  logic [p_width-1:0] wr_period,
  input  logic [p_width-1:0] wr_high,
  output logic               out,
  output logic               rise,
  output logic               fall,
  output logic               pending
);

  localparam logic [p_width-1:0] ONE   = p_width'(1);
  localparam logic [p_width-1:0] DEF_N = p_width'(p_default_period);
  localparam logic [p_width-1:0] DEF_H = p_width'(p_default_period / 2);

  logic [p_width-1:0] cnt_q, cnt_d;
  logic [p_width-1:0] n_q, n_d, h_q, h_d;
  logic [p_width-1:0] sh_n_q, sh_n_d, sh_h_q, sh_h_d;
  logic               pend_q, pend_d;
  logic               out_q, out_d, rise_q, rise_d, fall_q, fall_d;
  logic               wrap, advance, restart;
  cfg_t               clamped;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    cnt_d   = cnt_q;
    n_d     = n_q;
    h_d     = h_q;
    sh_n_d  = sh_n_q;
    sh_h_d  = sh_h_q;
    pend_d  = pend_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    clamped = clamp_cfg(cfg_word_t'(sh_n_q), cfg_word_t'(sh_h_q));

    wrap    = (cnt_q == n_q - ONE);
    advance = sync | ~stop;
    restart = sync | wrap;

    if (advance) begin
      cnt_d = restart ? '0 : cnt_q + ONE;
      // Swapping config only when the count returns to 0 keeps every
      // period whole: no runt or stretched pulse on a setting change.
      if (restart && pend_q) begin
        n_d    = p_width'(clamped.n);
        h_d    = p_width'(clamped.h);
        pend_d = 1'b0;
      end
      out_d  = (cnt_d < h_d);
      rise_d = out_d & ~out_q;
      fall_d = ~out_d & out_q;
    end

    // A write in the same cycle as an apply lands in the shadow afterwards,
    // so it stays pending for the following boundary.
    if (wr) begin
      sh_n_d = wr_period;
      sh_h_d = wr_high;
      pend_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their _d values from the same clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      n_q    <= DEF_N;
      h_q    <= DEF_H;
      // NOTE: the shadow is reset too; pend_q alone would suffice logically,
      // but a defined shadow keeps reset behaviour free of X in simulation.
      sh_n_q <= '0;
      sh_h_q <= '0;
      pend_q <= 1'b0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      n_q    <= n_d;
      h_q    <= h_d;
      sh_n_q <= sh_n_d;
      sh_h_q <= sh_h_d;
      pend_q <= pend_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out     = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign pending = pend_q;

endmodule

// File: rtl/clock_gen.sv
// Multi-channel programmable clock-enable generator: write decode, sync
// fan-out and per-channel divider instances.
module clock_gen
  import clock_pkg::*;
#(
  parameter int  p_channels       = 4,
  parameter int  p_width          = 16,
  parameter int  p_default_period = 50,
  localparam int CH_W             = ch_sel_width(p_channels)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [p_channels-1:0] i_stop,
  input  logic                  i_sync,
  input  logic                  i_wr,
  input  logic [CH_W-1:0]       i_wr_ch,
  input  logic [p_width-1:0]    i_wr_period,
  input  logic [p_width-1:0]    i_wr_high,
  output logic [p_channels-1:0] o_out,
  output logic [p_channels-1:0] o_rise,
  output logic [p_channels-1:0] o_fall,
  output logic [p_channels-1:0] o_pending
);

  logic [p_channels-1:0] wr_sel;

  // Out-of-range channel numbers match no index and are dropped here.
  always_comb begin
    wr_sel = '0;
    for (int c = 0; c < p_channels; c++) begin
      wr_sel[c] = i_wr && (i_wr_ch == CH_W'(c));
    end
  end

  for (genvar g = 0; g < p_channels; g++) begin : g_ch
    clock_channel #(
      .p_width         (p_width),
      .p_default_period(p_default_period)
    ) u_ch (
      .clk      (i_clk),
      .rst_n    (i_rst),
      .stop     (i_stop[g]),
      .sync     (i_sync),
      .wr       (wr_sel[g]),
      .wr_period(i_wr_period),
      .wr_high  (i_wr_high),
      .out      (o_out[g]),
      .rise     (o_rise[g]),
      .fall     (o_fall[g]),
      .pending  (o_pending[g])
    );
  end

endmodule
